subset_scan_ctrl: RTL and testbench
===================================

Name: subset_scan_ctrl

Overview:
- Frame-scan sequencer for the combinational circle-subset evaluator (Subset).
- Accepts one configuration (three centres, three radius-squares, mode) through a valid/ready handshake and latches it.
- Sweeps position_x/position_y over a GRID_W x GRID_H grid, one pixel per cycle, and samples the evaluator's activated bit.
- Packs each grid row into a word and hands it downstream (LED-matrix/frame-buffer writer) through a valid/ready handshake.

Parameters:
- GRID_W, 16, pixels per row; legal range 1..32.
- GRID_H, 16, rows per frame; legal range 1..32.
- COUNT_W, 11, width of active_count; must satisfy 2^COUNT_W > GRID_W*GRID_H.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_valid  in  1  configuration offered.
- cfg_ready  out  1  controller accepts configuration; 1 only in IDLE.
- cfg_central  in  24  {xA,yA,xB,yB,xC,yC} packed as the evaluator expects.
- cfg_radius_sq  in  24  {rA²,rB²,rC²}.
- cfg_mode  in  2  subset mode, passed through unchanged.
- eval_central  out  24  latched centres to the evaluator.
- eval_radius_sq  out  24  latched radius-squares to the evaluator.
- eval_mode  out  2  latched mode to the evaluator.
- eval_x  out  5  current pixel column.
- eval_y  out  5  current pixel row.
- eval_activated  in  1  evaluator result for (eval_x, eval_y), combinational.
- row_valid  out  1  row_data/row_index valid.
- row_ready  in  1  downstream accepts the row.
- row_data  out  GRID_W  bit x = activated at (x, row_index).
- row_index  out  5  row number of row_data.
- frame_done  out  1  one-cycle pulse after the last row handshake.
- busy  out  1  high in SCAN or EMIT.

Behaviour:
- Reset (async, rst_n=0) forces state IDLE.
- Reset values: eval_* = 0, row_data = 0, row_index = 0, row_valid = 0, frame_done = 0, busy = 0, cfg_ready = 1 (combinational, state==IDLE).
- Reset mid-frame discards the partial row and configuration. No row_valid or frame_done is emitted for that frame.
- States: IDLE, SCAN, EMIT.
- IDLE:
  - On cfg_valid & cfg_ready, latch cfg_* into eval_*, clear x, y and the row shift register, and go to SCAN next cycle.
  - cfg_valid without ready is ignored.
- SCAN:
  - eval_x = x and eval_y = y are registered. The evaluator is combinational, so eval_activated is valid in the same cycle.
  - Each clock, bit x of the row register is set to eval_activated and x increments.
  - When x == GRID_W-1 is sampled, x returns to 0, the assembled row loads into row_data, row_index = y, row_valid = 1, and the state goes to EMIT.
  - Row latency: GRID_W cycles from first pixel to row_valid.
- EMIT:
  - row_valid is held; row_data and row_index are stable until the handshake. Stall (row_ready=0) is unbounded.
  - On row_valid & row_ready with y < GRID_H-1: y increments, row_valid = 0, state returns to SCAN.
  - On row_valid & row_ready with y == GRID_H-1: row_valid = 0, frame_done = 1 for one cycle, state returns to IDLE.
  - row_ready may be high before row_valid; it has no effect outside EMIT.
- eval_* configuration is constant for the whole frame. cfg_ready = 0 while busy; cfg_valid during a frame is held off, not dropped.
- Timing:
  - Minimum frame = GRID_H*(GRID_W+1) cycles with row_ready tied high.
  - The next cfg can be accepted in the cycle frame_done is high, since the state is already IDLE.
- Width rules: x and y counters are 5 bits. Upper bits of row_data beyond GRID_W do not exist. GRID_W=1 means every SCAN lasts one cycle.

Optional Feature:
- Macro: SUBSET_SCAN_POPCOUNT_EN.
- Defined:
  - Adds output port active_count [COUNT_W-1:0], reset 0.
  - Cleared on cfg accept; incremented in each SCAN cycle where eval_activated = 1.
  - Final and stable from the frame_done cycle until the next cfg accept.
- Not defined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: after rst_n release, cfg_ready=1, busy=0, row_valid=0, eval_x=eval_y=0; no change over 50 cycles with cfg_valid=0.
- Diagonal frame: GRID_W=GRID_H=16, bench evaluator model activated=(eval_x==eval_y), row_ready=1 → rows 0..15 arrive with row_data=16'h0001<<row_index, frame_done exactly at cycle 272 after cfg accept, eval_* equal to the programmed cfg_central=24'h88_4C_C4, cfg_radius_sq=24'h10_10_10, cfg_mode=2'b11 throughout.
- Backpressure: same frame, row_ready low for 7 cycles on rows 3 and 15 → row_valid/row_data/row_index held stable, no pixel scanned while stalled, frame length 272+14 cycles.
- Config during frame: cfg_valid raised with new cfg at row 5 → cfg_ready=0 until frame_done cycle, eval_* unchanged; new cfg accepted in the frame_done cycle, next frame uses it.
- Reset mid-frame: rst_n pulsed low during row 9 SCAN → all outputs to reset values immediately, no frame_done, next cfg starts at row 0.
- Popcount (macro on): model activated=1 for all pixels → active_count=256 at frame_done; activated=(eval_x<4) → 64; reset to 0 on next cfg accept.

Source files
------------

// File: rtl/subset_scan_ctrl_if.sv
// rtl/subset_scan_ctrl_if.sv - config, evaluator and row-stream signals of the subset scan controller
// active_count is present only when SUBSET_SCAN_POPCOUNT_EN is defined.
interface subset_scan_ctrl_if #(
    parameter int GRID_W  = 16,
    parameter int COUNT_W = 11
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [23:0]       cfg_central;
    logic [23:0]       cfg_radius_sq;
    logic [1:0]        cfg_mode;
    logic [23:0]       eval_central;
    logic [23:0]       eval_radius_sq;
    logic [1:0]        eval_mode;
    logic [4:0]        eval_x;
    logic [4:0]        eval_y;
    logic              eval_activated;
    logic              row_valid;
    logic              row_ready;
    logic [GRID_W-1:0] row_data;
    logic [4:0]        row_index;
    logic              frame_done;
    logic              busy;
`ifdef SUBSET_SCAN_POPCOUNT_EN
    logic [COUNT_W-1:0] active_count;
`endif

    modport master (
`ifdef SUBSET_SCAN_POPCOUNT_EN
        input  active_count,
`endif
        output cfg_valid, cfg_central, cfg_radius_sq, cfg_mode, eval_activated, row_ready,
        input  cfg_ready, eval_central, eval_radius_sq, eval_mode, eval_x, eval_y,
        input  row_valid, row_data, row_index, frame_done, busy
    );

    modport slave (
`ifdef SUBSET_SCAN_POPCOUNT_EN
        output active_count,
`endif
        input  cfg_valid, cfg_central, cfg_radius_sq, cfg_mode, eval_activated, row_ready,
        output cfg_ready, eval_central, eval_radius_sq, eval_mode, eval_x, eval_y,
        output row_valid, row_data, row_index, frame_done, busy
    );
endinterface

// File: rtl/subset_scan_ctrl.sv
// rtl/subset_scan_ctrl.sv - frame-scan sequencer sweeping the subset evaluator and emitting packed rows
// Optional per-frame activated-pixel counter enabled by SUBSET_SCAN_POPCOUNT_EN.
module subset_scan_ctrl #(
    parameter int GRID_W  = 16,
    parameter int GRID_H  = 16,
    parameter int COUNT_W = 11
) (
    input  logic                clk,
    input  logic                rst_n,
    subset_scan_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, SCAN, EMIT} state_t;

    localparam logic [4:0] X_LAST = 5'(GRID_W - 1);
    localparam logic [4:0] Y_LAST = 5'(GRID_H - 1);

    state_t            state_q, state_d;
    logic [4:0]        x_q, x_d;
    logic [4:0]        y_q, y_d;
    logic [GRID_W-1:0] row_sr_q, row_sr_d;
    logic [GRID_W-1:0] row_data_q, row_data_d;
    logic [4:0]        row_index_q, row_index_d;
    logic              row_valid_q, row_valid_d;
    logic              frame_done_q, frame_done_d;
    logic [23:0]       central_q, central_d;
    logic [23:0]       radius_sq_q, radius_sq_d;
    logic [1:0]        mode_q, mode_d;
`ifdef SUBSET_SCAN_POPCOUNT_EN
    logic [COUNT_W-1:0] count_q, count_d;
`endif

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        row_sr_d     = row_sr_q;
        row_data_d   = row_data_q;
        row_index_d  = row_index_q;
        row_valid_d  = row_valid_q;
        frame_done_d = 1'b0;
        central_d    = central_q;
        radius_sq_d  = radius_sq_q;
        mode_d       = mode_q;
`ifdef SUBSET_SCAN_POPCOUNT_EN
        count_d      = count_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.cfg_valid) begin
                    central_d   = bus.cfg_central;
                    radius_sq_d = bus.cfg_radius_sq;
                    mode_d      = bus.cfg_mode;
                    x_d         = '0;
                    y_d         = '0;
                    row_sr_d    = '0;
`ifdef SUBSET_SCAN_POPCOUNT_EN
                    count_d     = '0;
`endif
                    state_d     = SCAN;
                end
            end
            SCAN: begin
                for (int i = 0; i < GRID_W; i++) begin
                    if (x_q == 5'(i)) row_sr_d[i] = bus.eval_activated;
                end
`ifdef SUBSET_SCAN_POPCOUNT_EN
                if (bus.eval_activated) count_d = count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
`endif
                // The last pixel's bit is folded in on the same edge the row is published.
                if (x_q == X_LAST) begin
                    x_d         = '0;
                    row_data_d  = row_sr_d;
                    row_index_d = y_q;
                    row_valid_d = 1'b1;
                    state_d     = EMIT;
                end else begin
                    x_d = x_q + 5'd1;
                end
            end
            EMIT: begin
                if (bus.row_ready) begin
                    row_valid_d = 1'b0;
                    if (y_q == Y_LAST) begin
                        y_d          = '0;
                        frame_done_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        y_d     = y_q + 5'd1;
                        state_d = SCAN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            row_sr_q     <= '0;
            row_data_q   <= '0;
            row_index_q  <= '0;
            row_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            central_q    <= '0;
            radius_sq_q  <= '0;
            mode_q       <= '0;
`ifdef SUBSET_SCAN_POPCOUNT_EN
            count_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            row_sr_q     <= row_sr_d;
            row_data_q   <= row_data_d;
            row_index_q  <= row_index_d;
            row_valid_q  <= row_valid_d;
            frame_done_q <= frame_done_d;
            central_q    <= central_d;
            radius_sq_q  <= radius_sq_d;
            mode_q       <= mode_d;
`ifdef SUBSET_SCAN_POPCOUNT_EN
            count_q      <= count_d;
`endif
        end
    end

    assign bus.cfg_ready      = (state_q == IDLE);
    assign bus.busy           = (state_q != IDLE);
    assign bus.eval_central   = central_q;
    assign bus.eval_radius_sq = radius_sq_q;
    assign bus.eval_mode      = mode_q;
    assign bus.eval_x         = x_q;
    assign bus.eval_y         = y_q;
    assign bus.row_valid      = row_valid_q;
    assign bus.row_data       = row_data_q;
    assign bus.row_index      = row_index_q;
    assign bus.frame_done     = frame_done_q;
`ifdef SUBSET_SCAN_POPCOUNT_EN
    assign bus.active_count   = count_q;
`endif
endmodule

// File: tb/tb_subset_scan_ctrl.sv
// tb/tb_subset_scan_ctrl.sv - directed self-checking bench for subset_scan_ctrl
module tb_subset_scan_ctrl;
    localparam int GW = 16;
    localparam int GH = 16;

    localparam logic [23:0] C1 = 24'h88_4C_C4;
    localparam logic [23:0] R1 = 24'h10_10_10;
    localparam logic [1:0]  M1 = 2'b11;
    localparam logic [23:0] C2 = 24'h12_34_56;
    localparam logic [23:0] R2 = 24'h09_19_29;
    localparam logic [1:0]  M2 = 2'b01;

    logic clk;
    logic rst_n;
    int   pat;
    int   total;
    int   bad;

    subset_scan_ctrl_if #(.GRID_W(GW), .COUNT_W(11)) ifc ();

    subset_scan_ctrl #(.GRID_W(GW), .GRID_H(GH), .COUNT_W(11)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic act(int p, int x, int y);
        case (p)
            0:       return x == y;
            1:       return 1'b1;
            default: return x < 4;
        endcase
    endfunction

    function automatic logic [GW-1:0] exp_row(int p, int r);
        logic [GW-1:0] v;
        for (int x = 0; x < GW; x++) v[x] = act(p, x, r);
        return v;
    endfunction

    always_comb ifc.eval_activated = act(pat, int'(ifc.eval_x), int'(ifc.eval_y));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic offer_cfg(input logic [23:0] c, input logic [23:0] r, input logic [1:0] m);
        @(negedge clk);
        ifc.cfg_valid     = 1'b1;
        ifc.cfg_central   = c;
        ifc.cfg_radius_sq = r;
        ifc.cfg_mode      = m;
        check("cfg_ready_offer", 32'(ifc.cfg_ready), 32'd1);
    endtask

    // Runs from the cycle after the accept edge up to the frame_done cycle.
    task automatic scan_frame(input int p, input bit stall_en, input bit offer_mid,
                              input logic [23:0] ec, input logic [23:0] er, input logic [1:0] em,
                              input int exp_len);
        int cyc, rows, stall_left;
        bit hold_ok, stall_ok, ready_ok, done_seen, in_row, mid_sent;
        logic [GW-1:0] cap_d;
        logic [4:0]    cap_i;
        cyc = 0; rows = 0; stall_left = 0;
        hold_ok = 1; stall_ok = 1; ready_ok = 1; done_seen = 0; in_row = 0; mid_sent = 0;
        cap_d = '0; cap_i = '0;
        pat = p;
        @(negedge clk);
        ifc.cfg_valid = 1'b0;
        while (!done_seen && cyc < 2000) begin
            if (ifc.eval_central !== ec || ifc.eval_radius_sq !== er || ifc.eval_mode !== em)
                hold_ok = 0;
            if (offer_mid && !mid_sent && ifc.eval_y == 5'd5) begin
                ifc.cfg_valid     = 1'b1;
                ifc.cfg_central   = C2;
                ifc.cfg_radius_sq = R2;
                ifc.cfg_mode      = M2;
                mid_sent          = 1;
            end
            if (mid_sent && !ifc.frame_done && ifc.cfg_ready) ready_ok = 0;
            if (ifc.frame_done) begin
                done_seen = 1;
            end else if (ifc.row_valid && !in_row) begin
                in_row = 1;
                cap_d  = ifc.row_data;
                cap_i  = ifc.row_index;
                check("row_data", 32'(ifc.row_data), 32'(exp_row(p, rows)));
                check("row_index", 32'(ifc.row_index), 32'(rows));
                if (stall_en && (rows == 3 || rows == 15)) begin
                    ifc.row_ready = 1'b0;
                    stall_left    = 7;
                end
                rows++;
            end else if (ifc.row_valid && stall_left > 0) begin
                if (ifc.row_data !== cap_d || ifc.row_index !== cap_i ||
                    ifc.eval_x !== 5'd0 || ifc.eval_y !== cap_i)
                    stall_ok = 0;
                stall_left--;
                if (stall_left == 0) ifc.row_ready = 1'b1;
            end else if (!ifc.row_valid) begin
                in_row = 0;
            end
            if (!done_seen) begin
                @(negedge clk);
                cyc++;
            end
        end
        check("frame_len", 32'(cyc), 32'(exp_len));
        check("row_count", 32'(rows), 32'(GH));
        check("eval_cfg_hold", 32'(hold_ok), 32'd1);
        check("stall_stable", 32'(stall_ok), 32'd1);
        check("cfg_held_off", 32'(ready_ok), 32'd1);
    endtask

    initial begin
        bit idle_ok, quiet_ok;
        int guard;
        total = 0; bad = 0; pat = 0;
        rst_n = 1'b0;
        ifc.cfg_valid = 1'b0; ifc.cfg_central = '0; ifc.cfg_radius_sq = '0; ifc.cfg_mode = '0;
        ifc.row_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_cfg_ready", 32'(ifc.cfg_ready), 32'd1);
        check("rst_busy", 32'(ifc.busy), 32'd0);
        check("rst_row_valid", 32'(ifc.row_valid), 32'd0);
        check("rst_eval_xy", 32'({ifc.eval_x, ifc.eval_y}), 32'd0);
        check("rst_row_data", 32'(ifc.row_data), 32'd0);
        check("rst_row_index", 32'(ifc.row_index), 32'd0);
        check("rst_frame_done", 32'(ifc.frame_done), 32'd0);
        check("rst_eval_cfg", 32'(ifc.eval_central ^ ifc.eval_radius_sq) | 32'(ifc.eval_mode), 32'd0);
        idle_ok = 1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!ifc.cfg_ready || ifc.busy || ifc.row_valid || ifc.frame_done ||
                ifc.eval_x != 0 || ifc.eval_y != 0)
                idle_ok = 0;
        end
        check("idle_stable", 32'(idle_ok), 32'd1);

        offer_cfg(C1, R1, M1);
        scan_frame(0, 0, 0, C1, R1, M1, 272);
        @(negedge clk);
        check("frame_done_pulse", 32'(ifc.frame_done), 32'd0);
        check("idle_after_frame", 32'(ifc.busy), 32'd0);

        offer_cfg(C1, R1, M1);
        scan_frame(0, 1, 0, C1, R1, M1, 286);

        offer_cfg(C1, R1, M1);
        scan_frame(0, 0, 1, C1, R1, M1, 272);
        check("cfg_ready_at_done", 32'(ifc.cfg_ready), 32'd1);
        scan_frame(0, 0, 0, C2, R2, M2, 272);

        offer_cfg(C1, R1, M1);
        guard = 0;
        @(negedge clk);
        ifc.cfg_valid = 1'b0;
        while (!(ifc.eval_y == 5'd9 && ifc.eval_x == 5'd6) && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check("reach_row9", 32'(guard < 1000), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(ifc.busy), 32'd0);
        check("midrst_cfg_ready", 32'(ifc.cfg_ready), 32'd1);
        check("midrst_eval_xy", 32'({ifc.eval_x, ifc.eval_y}), 32'd0);
        check("midrst_eval_cfg", 32'(ifc.eval_central), 32'd0);
        check("midrst_row", 32'({ifc.row_valid, ifc.row_data}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        quiet_ok = 1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ifc.row_valid || ifc.frame_done || ifc.busy) quiet_ok = 0;
        end
        check("midrst_quiet", 32'(quiet_ok), 32'd1);
        offer_cfg(C2, R2, M2);
        scan_frame(2, 0, 0, C2, R2, M2, 272);

`ifdef SUBSET_SCAN_POPCOUNT_EN
        offer_cfg(C1, R1, M1);
        scan_frame(1, 0, 0, C1, R1, M1, 272);
        check("popcount_all", 32'(ifc.active_count), 32'd256);
        offer_cfg(C1, R1, M1);
        @(posedge clk);
        #1;
        check("popcount_clear", 32'(ifc.active_count), 32'd0);
        scan_frame(2, 0, 0, C1, R1, M1, 272);
        check("popcount_x_lt4", 32'(ifc.active_count), 32'd64);
        @(negedge clk);
        check("popcount_stable", 32'(ifc.active_count), 32'd64);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
